ex_mem_reg: RTL and testbench

- Pipeline register between the EX stage and the MEM stage. Registers EX's GPR write request and HI/LO write request toward MEM.
- Implements the stall/bubble/flush rules for the EX→MEM boundary.
- Holds the intermediate 64-bit product and step counter that EX needs for two-cycle MADD/MADDU/MSUB/MSUBU while EX is stalled, and feeds them back to EX.

---
 rtl/ex_mem_reg.sv | 157 +++++++++++++++
 tb/tb_ex_mem_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with stall, bubble, flush and multi-cycle accumulate hold
//
// Purpose:
//   Registers the EX stage GPR and HI/LO write requests toward MEM.
//   Applies the boundary rules, in priority order: reset, flush, hold, bubble, advance.
//   Keeps the partial 64-bit product and the step count of a two-cycle
//   MADD/MADDU/MSUB/MSUBU while EX is stalled, and returns them to EX.
//   Every output is registered, so the latency is one cycle.
//
// Optional feature:
//   Define EX_MEM_PERF_CNT_EN to add the performance counters
//   perf_inst_o, perf_bubble_o and perf_acc_o.
//
// Packed field layouts:
//   wreg (38 bits) = {en[37], addr[36:32], data[31:0]}
//   hilo (65 bits) = {en[64], hi[63:32], lo[31:0]}
//
// Ports:
//   clk            pipeline clock; all state changes on the rising edge
//   rst            synchronous reset, active high
//   ex_stall_i     EX stage stalled this cycle
//   mem_stall_i    MEM stage stalled this cycle
//   flush_i        pipeline flush; clears the register contents
//   ex_wreg_i      GPR write request from EX
//   ex_hilo_i      HI/LO write request from EX
//   ex_acc_i       intermediate accumulate value from EX
//   ex_cnt_i       EX multi-cycle step count
//   mem_wreg_o     registered GPR write request to MEM
//   mem_hilo_o     registered HI/LO write request to MEM
//   ex_acc_o       held accumulate value returned to EX
//   ex_cnt_o       held step count returned to EX
//   perf_inst_o    (optional) ADVANCE cycles that carry a GPR or HI/LO write
//   perf_bubble_o  (optional) BUBBLE cycles
//   perf_acc_o     (optional) cycles spent in the ACC state

module ex_mem_reg #(
    parameter int CNT_W = 2,
    parameter int ACC_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_stall_i,
    input  logic             mem_stall_i,
    input  logic             flush_i,
    input  logic [37:0]      ex_wreg_i,
    input  logic [64:0]      ex_hilo_i,
    input  logic [ACC_W-1:0] ex_acc_i,
    input  logic [CNT_W-1:0] ex_cnt_i,
    output logic [37:0]      mem_wreg_o,
    output logic [64:0]      mem_hilo_o,
    output logic [ACC_W-1:0] ex_acc_o,
    output logic [CNT_W-1:0] ex_cnt_o
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]      perf_inst_o,
    output logic [31:0]      perf_bubble_o,
    output logic [31:0]      perf_acc_o
`endif
);

    localparam logic RST_ENABLE = 1'b1;

    localparam int WREG_EN_BIT = 37;
    localparam int HILO_EN_BIT = 64;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t state;

    // Classify the cycle once. Flush outranks the stall cases. A stalled MEM
    // holds whatever EX is doing, which also covers the illegal
    // ex_stall_i=0 / mem_stall_i=1 pairing.
    logic is_hold;
    logic is_bubble;
    logic is_advance;

    always_comb begin
        is_hold    = 1'b0;
        is_bubble  = 1'b0;
        is_advance = 1'b0;
        if (!flush_i) begin
            if (mem_stall_i) begin
                is_hold = 1'b1;
            end else if (ex_stall_i) begin
                is_bubble = 1'b1;
            end else begin
                is_advance = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            mem_wreg_o <= '0;
            mem_hilo_o <= '0;
            ex_acc_o   <= '0;
            ex_cnt_o   <= '0;
            state      <= IDLE;
        end else if (flush_i) begin
            mem_wreg_o <= '0;
            mem_hilo_o <= '0;
            ex_acc_o   <= '0;
            ex_cnt_o   <= '0;
            state      <= IDLE;
        end else if (is_bubble) begin
            // EX is stuck: send a NOP to MEM and keep EX's partial result
            // so it can pick it up on its next cycle.
            mem_wreg_o <= '0;
            mem_hilo_o <= '0;
            ex_acc_o   <= ex_acc_i;
            ex_cnt_o   <= ex_cnt_i;
            if (ex_cnt_i != '0) begin
                state <= ACC;
            end
        end else if (is_advance) begin
            // Any multi-cycle op is finished once EX advances.
            mem_wreg_o <= ex_wreg_i;
            mem_hilo_o <= ex_hilo_i;
            ex_acc_o   <= '0;
            ex_cnt_o   <= '0;
            state      <= IDLE;
        end
        // is_hold: every register keeps its value.
    end

`ifdef EX_MEM_PERF_CNT_EN
    // These counters survive flushes and wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            perf_inst_o   <= '0;
            perf_bubble_o <= '0;
            perf_acc_o    <= '0;
        end else begin
            if (is_advance && (ex_wreg_i[WREG_EN_BIT] || ex_hilo_i[HILO_EN_BIT])) begin
                perf_inst_o <= perf_inst_o + 32'd1;
            end
            if (is_bubble) begin
                perf_bubble_o <= perf_bubble_o + 32'd1;
            end
            if (state == ACC) begin
                perf_acc_o <= perf_acc_o + 32'd1;
            end
        end
    end
`endif

    // While an accumulate is in flight, EX may only release its stall with a
    // live step count. The one exception is the cycle after a flush.
    acc_release_has_count: assert property (
        @(posedge clk) disable iff (rst == RST_ENABLE)
        ((state == ACC) && !ex_stall_i) |-> ((ex_cnt_i != '0) || $past(flush_i))
    );

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - self-checking bench for ex_mem_reg

module tb_ex_mem_reg;

    logic        clk;
    logic        rst;
    logic        ex_stall_i;
    logic        mem_stall_i;
    logic        flush_i;
    logic [37:0] ex_wreg_i;
    logic [64:0] ex_hilo_i;
    logic [63:0] ex_acc_i;
    logic [1:0]  ex_cnt_i;
    logic [37:0] mem_wreg_o;
    logic [64:0] mem_hilo_o;
    logic [63:0] ex_acc_o;
    logic [1:0]  ex_cnt_o;
`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] perf_inst_o;
    logic [31:0] perf_bubble_o;
    logic [31:0] perf_acc_o;
`endif

    ex_mem_reg #(.CNT_W(2), .ACC_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_stall_i  (ex_stall_i),
        .mem_stall_i (mem_stall_i),
        .flush_i     (flush_i),
        .ex_wreg_i   (ex_wreg_i),
        .ex_hilo_i   (ex_hilo_i),
        .ex_acc_i    (ex_acc_i),
        .ex_cnt_i    (ex_cnt_i),
        .mem_wreg_o  (mem_wreg_o),
        .mem_hilo_o  (mem_hilo_o),
        .ex_acc_o    (ex_acc_o),
        .ex_cnt_o    (ex_cnt_o)
`ifdef EX_MEM_PERF_CNT_EN
        ,
        .perf_inst_o   (perf_inst_o),
        .perf_bubble_o (perf_bubble_o),
        .perf_acc_o    (perf_acc_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference outputs
    logic [37:0] exp_wreg;
    logic [64:0] exp_hilo;
    logic [63:0] exp_acc;
    logic [1:0]  exp_cnt;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Reference rule: reset > flush > MEM stalled (keep) > EX stalled (NOP + capture) > advance.
    task automatic model_edge();
        if (rst) begin
            exp_wreg = '0; exp_hilo = '0; exp_acc = '0; exp_cnt = '0;
        end else if (flush_i) begin
            exp_wreg = '0; exp_hilo = '0; exp_acc = '0; exp_cnt = '0;
        end else if (mem_stall_i) begin
            exp_wreg = exp_wreg;
        end else if (ex_stall_i) begin
            exp_wreg = '0; exp_hilo = '0; exp_acc = ex_acc_i; exp_cnt = ex_cnt_i;
        end else begin
            exp_wreg = ex_wreg_i; exp_hilo = ex_hilo_i; exp_acc = '0; exp_cnt = '0;
        end
    endtask

    // Drive one cycle at the falling edge, apply the model at the rising edge,
    // and return at the next falling edge with outputs settled.
    task automatic step(input logic r, input logic es, input logic ms, input logic fl,
                        input logic [37:0] w, input logic [64:0] h,
                        input logic [63:0] a, input logic [1:0] c);
        rst = r; ex_stall_i = es; mem_stall_i = ms; flush_i = fl;
        ex_wreg_i = w; ex_hilo_i = h; ex_acc_i = a; ex_cnt_i = c;
        @(posedge clk);
        model_edge();
        cmp_en = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_wreg", mem_wreg_o, exp_wreg);
            check("cyc_hilo", mem_hilo_o, exp_hilo);
            check("cyc_acc",  ex_acc_o,   exp_acc);
            check("cyc_cnt",  ex_cnt_o,   exp_cnt);
        end
    end

    function automatic logic [37:0] rnd_wreg();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[37:0];
    endfunction

    function automatic logic [64:0] rnd_hilo();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[64:0];
    endfunction

    function automatic logic [63:0] rnd_acc();
        return {$urandom(), $urandom()};
    endfunction

    logic r_r, r_es, r_ms, r_fl;
    logic [1:0] r_c;

    initial begin
        rst = 1'b1; ex_stall_i = 1'b0; mem_stall_i = 1'b0; flush_i = 1'b0;
        ex_wreg_i = '0; ex_hilo_i = '0; ex_acc_i = '0; ex_cnt_i = '0;
        exp_wreg = '0; exp_hilo = '0; exp_acc = '0; exp_cnt = '0;
        @(negedge clk);

        // Reset held for two edges with random inputs
        step(1, 1, 0, 1, rnd_wreg(), rnd_hilo(), rnd_acc(), 2'd3);
        step(1, 0, 0, 0, rnd_wreg(), rnd_hilo(), rnd_acc(), 2'd1);
        check("rst_wreg", mem_wreg_o, 38'd0);
        check("rst_hilo", mem_hilo_o, 65'd0);
        check("rst_acc",  ex_acc_o,   64'd0);
        check("rst_cnt",  ex_cnt_o,   2'd0);

        // First advance after reset
        step(0, 0, 0, 0, {1'b1, 5'd3, 32'h1234_5678}, '0, 64'h55, 2'd0);
        check("adv_first", mem_wreg_o, {1'b1, 5'd3, 32'h1234_5678});

        // Back-to-back advance stream
        step(0, 0, 0, 0, {1'b1, 5'd7, 32'hA5A5_A5A5}, '0, 64'h1, 2'd2);
        check("adv_a", mem_wreg_o, {1'b1, 5'd7, 32'hA5A5_A5A5});
        check("adv_a_acc", ex_acc_o, 64'd0);
        step(0, 0, 0, 0, {1'b1, 5'd8, 32'h5A5A_5A5A}, '0, 64'h2, 2'd3);
        check("adv_b", mem_wreg_o, {1'b1, 5'd8, 32'h5A5A_5A5A});
        check("adv_b_cnt", ex_cnt_o, 2'd0);

        // Bubble capturing the MADD partial product, then completion
        step(0, 1, 0, 0, {1'b1, 5'd9, 32'hFFFF_0000}, {1'b1, 64'h7}, 64'h0000_0001_FFFF_FFFE, 2'd1);
        check("bub_wreg_en", mem_wreg_o[37], 1'b0);
        check("bub_hilo_en", mem_hilo_o[64], 1'b0);
        check("bub_acc", ex_acc_o, 64'h0000_0001_FFFF_FFFE);
        check("bub_cnt", ex_cnt_o, 2'd1);
        step(0, 0, 0, 0, '0, {1'b1, 32'h2, 32'h0}, 64'h9, 2'd2);
        check("madd_hilo", mem_hilo_o, {1'b1, 32'h2, 32'h0});
        check("madd_acc", ex_acc_o, 64'd0);
        check("madd_cnt", ex_cnt_o, 2'd0);

        // MEM stall holds everything for three cycles
        step(0, 0, 0, 0, {1'b1, 5'd4, 32'hDEAD_BEEF}, '0, 64'h0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, rnd_wreg(), rnd_hilo(), rnd_acc(), 2'(i + 1));
            check("hold_wreg", mem_wreg_o, {1'b1, 5'd4, 32'hDEAD_BEEF});
        end

        // Flush while accumulating and MEM stalled
        step(0, 1, 0, 0, rnd_wreg(), rnd_hilo(), 64'hCAFE_F00D_1234_0001, 2'd3);
        check("acc_pre_flush", ex_acc_o, 64'hCAFE_F00D_1234_0001);
        step(0, 1, 1, 1, rnd_wreg(), rnd_hilo(), rnd_acc(), 2'd2);
        check("flush_wreg", mem_wreg_o, 38'd0);
        check("flush_hilo", mem_hilo_o, 65'd0);
        check("flush_acc",  ex_acc_o,   64'd0);
        check("flush_cnt",  ex_cnt_o,   2'd0);
        step(0, 0, 0, 0, {1'b1, 5'd1, 32'h1}, '0, 64'h0, 2'd0);
        step(0, 0, 0, 0, {1'b1, 5'd2, 32'h2}, '0, 64'h0, 2'd0);
        check("post_flush_adv", mem_wreg_o, {1'b1, 5'd2, 32'h2});

        // Reset in the middle of an accumulate, with MEM stalled
        step(0, 1, 0, 0, rnd_wreg(), rnd_hilo(), 64'h1111_2222_3333_4444, 2'd1);
        step(1, 1, 1, 0, rnd_wreg(), rnd_hilo(), rnd_acc(), 2'd1);
        check("rst_mid_acc", ex_acc_o, 64'd0);
        check("rst_mid_cnt", ex_cnt_o, 2'd0);
        step(0, 0, 0, 0, '0, {1'b1, 32'hAB, 32'hCD}, 64'h0, 2'd0);
        check("post_rst_hilo", mem_hilo_o, {1'b1, 32'hAB, 32'hCD});

        // Mixed legal traffic checked cycle by cycle against the model
        for (int i = 0; i < 40; i++) begin
            r_r  = ($urandom_range(0, 19) == 0);
            r_fl = ($urandom_range(0, 9) == 0);
            r_ms = ($urandom_range(0, 3) == 0);
            r_es = r_ms | ($urandom_range(0, 2) == 0);
            r_c  = 2'($urandom_range(1, 3));
            step(r_r, r_es, r_ms, r_fl, rnd_wreg(), rnd_hilo(), rnd_acc(), r_c);
        end

`ifdef EX_MEM_PERF_CNT_EN
        step(1, 0, 0, 0, '0, '0, '0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0, {1'b1, 5'(i), 32'(i)}, '0, '0, 2'd0);
        end
        step(0, 1, 0, 0, '0, '0, 64'h5, 2'd0);
        step(0, 1, 0, 0, '0, '0, 64'h6, 2'd1);
        step(0, 0, 0, 0, '0, '0, '0, 2'd1);
        check("perf_inst",   perf_inst_o,   32'd5);
        check("perf_bubble", perf_bubble_o, 32'd2);
        check("perf_acc",    perf_acc_o,    32'd1);
        force dut.perf_inst_o = 32'hFFFF_FFFF;
        #1;
        release dut.perf_inst_o;
        step(0, 0, 0, 0, {1'b1, 5'd6, 32'h6}, '0, '0, 2'd0);
        check("perf_wrap", perf_inst_o, 32'd0);
`endif

        cmp_en = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
